serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor. Computes diff = a - b, LSB first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop.
- Inverse arithmetic companion to the team's full-adder cell. Area-cheap alternative to a parallel subtractor for datapath blocks that can tolerate WIDTH-cycle latency.
- Operands are captured with a start/busy/done handshake.

Parameters:
- WIDTH, 8: operand and result width in bits (minimum 2).

Ports:
- clk  input  1  single system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured when start accepted
- b  input  WIDTH  subtrahend, captured when start accepted
- busy  output  1  high while subtraction in progress (SHIFT state)
- done  output  1  one-cycle pulse; diff/borrow_out valid
- diff  output  WIDTH  result (a - b) mod 2^WIDTH
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned, including borrow_in when enabled)

Behaviour:
- Reset (rst=1 at rising edge): state=IDLE, busy=0, done=0, diff=0, borrow_out=0, internal borrow=0, bit counter=0, operand shift registers=0. Reset has priority over all other inputs.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge: load a and b into shift registers, clear diff shift register, borrow=initial borrow (0, or borrow_in per optional feature), counter=0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, each edge:
  - Take a0/b0 = shift-register LSBs and br = borrow.
  - Compute d = a0^b0^br and br' = (~a0&b0) | (~(a0^b0)&br).
  - Shift d into diff MSB (diff shifts right).
  - Shift operand registers right.
  - borrow=br', counter+1.
  - When counter = WIDTH-1 at the edge, that edge processes the last bit: go to DONE and latch borrow_out=br'.
- DONE: done=1 for exactly this one cycle; next edge goes to IDLE.
- busy=1 exactly in SHIFT (WIDTH cycles).
- Latency: start sampled at edge of cycle N → busy in cycles N+1..N+WIDTH → done=1 in cycle N+WIDTH+1 → earliest next accepted start at edge of cycle N+WIDTH+2.
- diff and borrow_out hold their final values from DONE until the next accepted start. Intermediate diff contents during SHIFT are not valid.
- start in SHIFT or DONE: ignored; no queuing. a/b changes outside the accept edge have no effect.
- rst asserted mid-SHIFT: operation aborted; all outputs take reset values at that edge; no done pulse.
- start and rst both high on the same edge: reset wins; start is not accepted.
- Counter width: clog2(WIDTH)+1 bits; no wrap within an operation.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_BORROW_IN_EN.
- Defined: adds input port borrow_in (1 bit, after b). It is sampled with start in IDLE as the initial borrow, giving diff = (a - b - borrow_in) mod 2^WIDTH. This allows multi-word chaining via borrow_out.
- Undefined: no borrow_in port; initial borrow is constant 0.

Test Plan (WIDTH=8):
- Reset 2 cycles, then idle 3 cycles → busy=0, done=0, diff=0x00, borrow_out=0 throughout.
- a=0x05, b=0x03, start pulse at cycle N → busy high for cycles N+1..N+8; done=1 only in cycle N+9 with diff=0x02, borrow_out=0; values hold afterwards.
- a=0x03, b=0x05 → diff=0xFE, borrow_out=1. Then a=0x00, b=0x00 → diff=0x00, borrow_out=0. Then a=0xFF, b=0x01 → diff=0xFE, borrow_out=0.
- a=0x10, b=0x01 started; at busy cycle 3, drive start=1 with a=0xAA, b=0x55 → ignored; result diff=0x0F, borrow_out=0, single done pulse.
- Start a=0x80, b=0x01; assert rst for 1 cycle during busy cycle 4 → next cycle busy=0, diff=0x00, no done pulse. New start a=0x80, b=0x01 → diff=0x7F.
- With SERIAL_SUBTRACTOR_BORROW_IN_EN defined:
  - a=0x10, b=0x0F, borrow_in=1 → diff=0x00, borrow_out=0.
  - a=0x00, b=0x00, borrow_in=1 → diff=0xFF, borrow_out=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one full-subtractor step per clock.
// Optional macro SERIAL_SUBTRACTOR_BORROW_IN_EN adds a borrow_in port used as the initial borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
  input  logic             borrow_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             borrow_out_q, borrow_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             init_borrow;
  logic             bit_d;
  logic             bit_borrow;

`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
  assign init_borrow = borrow_in;
`else
  assign init_borrow = 1'b0;
`endif

  // Full-subtractor cell on the current operand LSBs and the stored borrow.
  assign bit_d      = a_q[0] ^ b_q[0] ^ borrow_q;
  assign bit_borrow = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          diff_d   = '0;
          borrow_d = init_borrow;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        diff_d   = {bit_d, diff_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = bit_borrow;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          borrow_out_d = bit_borrow;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      cnt_q        <= cnt_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, multi-cycle corner cases
// and randomized operations checked against an arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         bin_i;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a_i),
    .b          (b_i),
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    .borrow_in  (bin_i),
`endif
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic; the top bit is the final borrow.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    return r;
  endfunction

  // One operation; inject_cyc/rst_cyc (0 = unused) select a busy cycle for
  // an ignored start or a reset abort.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] exp_diff, input logic exp_bout,
                        input int inject_cyc, input int rst_cyc, input string nm);
    @(negedge clk);
    start = 1'b1; a_i = a; b_i = b; bin_i = bin;
    @(negedge clk);
    start = 1'b0; a_i = W'($urandom); b_i = W'($urandom); bin_i = 1'($urandom);
    for (int c = 1; c <= W; c++) begin
      if (c > 1) @(negedge clk);
      check({nm, " busy"}, {31'b0, busy}, 32'd1);
      check({nm, " done_early"}, {31'b0, done}, 32'd0);
      if (c == inject_cyc) begin
        start = 1'b1; a_i = 8'hAA; b_i = 8'h55;
      end else if (c == inject_cyc + 1) begin
        start = 1'b0;
      end
      if (c == rst_cyc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({nm, " abort_busy"}, {31'b0, busy}, 32'd0);
        check({nm, " abort_diff"}, {24'b0, diff}, 32'd0);
        check({nm, " abort_bout"}, {31'b0, borrow_out}, 32'd0);
        for (int k = 0; k < W + 2; k++) begin
          check({nm, " abort_no_done"}, {31'b0, done}, 32'd0);
          @(negedge clk);
        end
        $display("op %s: a=%02h b=%02h aborted by reset", nm, a, b);
        return;
      end
    end
    start = 1'b0;
    @(negedge clk);
    check({nm, " done"}, {31'b0, done}, 32'd1);
    check({nm, " busy_in_done"}, {31'b0, busy}, 32'd0);
    check({nm, " diff"}, {24'b0, diff}, {24'b0, exp_diff});
    check({nm, " bout"}, {31'b0, borrow_out}, {31'b0, exp_bout});
    @(negedge clk);
    check({nm, " done_pulse"}, {31'b0, done}, 32'd0);
    check({nm, " diff_hold"}, {24'b0, diff}, {24'b0, exp_diff});
    check({nm, " bout_hold"}, {31'b0, borrow_out}, {31'b0, exp_bout});
    $display("op %s: a=%02h b=%02h bin=%0d -> diff=%02h borrow_out=%0d", nm, a, b, bin,
             diff, borrow_out);
  endtask

  vec_t vecs[$];

  initial begin
    logic [W:0]   r;
    logic [W-1:0] ra, rb;
    logic         rbin;

    vecs.push_back('{8'h05, 8'h03, 1'b0, 8'h02, 1'b0});
    vecs.push_back('{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0});
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    vecs.push_back('{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1});
`endif

    rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0; bin_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset diff", {24'b0, diff}, 32'd0);
      check("reset bout", {31'b0, borrow_out}, 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle busy", {31'b0, busy}, 32'd0);
      check("idle done", {31'b0, done}, 32'd0);
      check("idle diff", {24'b0, diff}, 32'd0);
      check("idle bout", {31'b0, borrow_out}, 32'd0);
    end

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_bout, 0, 0,
             $sformatf("vec%0d", i));

    // start during busy cycle 3 must be ignored
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 3, 0, "ignore_start");
    // reset during busy cycle 4 aborts; a fresh operation then completes normally
    run_op(8'h80, 8'h01, 1'b0, 8'h00, 1'b0, 0, 4, "abort");
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 0, 0, "after_abort");

    // start and rst together: reset wins
    @(negedge clk);
    start = 1'b1; rst = 1'b1; a_i = 8'h44; b_i = 8'h11;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("start_with_rst busy", {31'b0, busy}, 32'd0);
    check("start_with_rst diff", {24'b0, diff}, 32'd0);
    $display("op start_with_rst: busy=%0d diff=%02h", busy, diff);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
      rbin = 1'($urandom);
`else
      rbin = 1'b0;
`endif
      r = ref_sub(ra, rb, rbin);
      run_op(ra, rb, rbin, r[W-1:0], r[W], 0, 0, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
